// File: rtl/contador_mod_tick_pkg.sv
// ---------------------------------------------------------------------------
// contador_mod_tick_pkg
// Shared constants for the modulo-N tick counter and its prescaler.
//   DIR_UP / DIR_DOWN    : encoding of the up_down input
//   DEFAULT_MODULUS      : 0..25 sequence of the original counter
//   DEFAULT_PRESCALE     : one tick per second on the 50 MHz board clock
//   DEFAULT_PS_WIDTH     : prescaler width able to hold DEFAULT_PRESCALE-1
// ---------------------------------------------------------------------------
package contador_mod_tick_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int DEFAULT_WIDTH    = 8;
  localparam int DEFAULT_MODULUS  = 26;
  localparam int DEFAULT_PRESCALE = 50_000_000;
  localparam int DEFAULT_PS_WIDTH = 26;

endpackage : contador_mod_tick_pkg

// File: rtl/contador_mod_tick_tick_gen.sv
// ---------------------------------------------------------------------------
// tick_gen
// Free-running prescaler producing a one-cycle enable strobe every PRESCALE
// clk cycles. Everything stays in the clk domain; no derived clock is made.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset (prescaler back to 0)
//   tick : high for one clk when the prescaler reaches PRESCALE-1
//          (constantly high when PRESCALE = 1)
// Parameters:
//   PRESCALE : clk cycles per tick, >= 1
//   PS_WIDTH : prescaler width, 2**PS_WIDTH >= PRESCALE
// ---------------------------------------------------------------------------
module tick_gen
  import contador_mod_tick_pkg::*;
#(
  parameter int PRESCALE = DEFAULT_PRESCALE,
  parameter int PS_WIDTH = DEFAULT_PS_WIDTH
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam logic [PS_WIDTH-1:0] PS_LAST = PS_WIDTH'(PRESCALE - 1);

  logic [PS_WIDTH-1:0] ps_q;
  logic [PS_WIDTH-1:0] ps_d;

  // Combinational from the registered prescaler so the strobe lines up with
  // the edge at which the counter consumes it.
  assign tick = (ps_q == PS_LAST);

  always_comb begin
    ps_d = ps_q + PS_WIDTH'(1);
    if (tick) begin
      ps_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ps_q <= '0;
    end else begin
      ps_q <= ps_d;
    end
  end

endmodule : tick_gen

// File: rtl/contador_mod_tick.sv
// ---------------------------------------------------------------------------
// contador_mod_tick
// Parametrised modulo-MODULUS up/down counter advanced by an internal
// prescaler strobe. Adds synchronous clear, hold, a registered terminal-count
// pulse and, when CONTADOR_LOAD_EN is defined, a clamped parallel load.
// Ports:
//   clk        : system clock, rising edge
//   rst        : synchronous active-high reset
//   hold       : 1 freezes count (prescaler keeps running, ticks are dropped)
//   up_down    : 1 = count up, 0 = count down
//   clear      : synchronous clear of count
//   load       : parallel load strobe        (CONTADOR_LOAD_EN only)
//   load_value : load data, clamped to MODULUS-1 (CONTADOR_LOAD_EN only)
//   count      : current count, registered
//   tick       : prescaler strobe
//   tc         : registered one-cycle pulse on the wrap cycle
// Update priority: rst > clear > load > (tick & !hold) > hold value.
// ---------------------------------------------------------------------------
module contador_mod_tick
  import contador_mod_tick_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int MODULUS  = DEFAULT_MODULUS,
  parameter int PRESCALE = DEFAULT_PRESCALE,
  parameter int PS_WIDTH = DEFAULT_PS_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic             up_down,
  input  logic             clear,
`ifdef CONTADOR_LOAD_EN
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
`endif
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             tc
);

  // MODULUS may equal 2**WIDTH, so the top value is formed from MODULUS-1
  // and the wrap is an explicit compare, never a natural overflow.
  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             tc_q;
  logic             tc_d;

  tick_gen #(
    .PRESCALE (PRESCALE),
    .PS_WIDTH (PS_WIDTH)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    if (clear) begin
      count_d = '0;
    end
`ifdef CONTADOR_LOAD_EN
    else if (load) begin
      count_d = (load_value > CNT_MAX) ? CNT_MAX : load_value;
    end
`endif
    else if (tick && !hold) begin
      if (up_down == DIR_UP) begin
        // >= also recovers cleanly if count were ever above the top value
        if (count_q >= CNT_MAX) begin
          count_d = '0;
          tc_d    = 1'b1;
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end else begin
        if (count_q == '0) begin
          count_d = CNT_MAX;
          tc_d    = 1'b1;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;

endmodule : contador_mod_tick

// File: tb/tb_contador_mod_tick.sv
// ---------------------------------------------------------------------------
// tb_contador_mod_tick
// Two instances share one set of inputs:
//   A : WIDTH=8, MODULUS=26,  PRESCALE=4
//   B : WIDTH=8, MODULUS=256, PRESCALE=1 (tick constantly high)
// A reference model predicts count/tc/tick for each instance; predictions
// are queued when a step is driven and popped after the clock edge.
// ---------------------------------------------------------------------------
module tb_contador_mod_tick;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       hold = 1'b0;
  logic       up_down = 1'b1;
  logic       clear = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_value = 8'd0;

  logic [7:0] count_a, count_b;
  logic       tick_a, tick_b, tc_a, tc_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  contador_mod_tick #(.WIDTH(8), .MODULUS(26), .PRESCALE(4), .PS_WIDTH(3)) dut_a (
    .clk        (clk),
    .rst        (rst),
    .hold       (hold),
    .up_down    (up_down),
    .clear      (clear),
`ifdef CONTADOR_LOAD_EN
    .load       (load),
    .load_value (load_value),
`endif
    .count      (count_a),
    .tick       (tick_a),
    .tc         (tc_a)
  );

  contador_mod_tick #(.WIDTH(8), .MODULUS(256), .PRESCALE(1), .PS_WIDTH(1)) dut_b (
    .clk        (clk),
    .rst        (rst),
    .hold       (hold),
    .up_down    (up_down),
    .clear      (clear),
`ifdef CONTADOR_LOAD_EN
    .load       (load),
    .load_value (load_value),
`endif
    .count      (count_b),
    .tick       (tick_b),
    .tc         (tc_b)
  );

  typedef struct {
    logic [7:0] cnt;
    logic       tc;
    logic       tick;
  } exp_t;

  exp_t sb[$];

  int m_ps  [2];
  int m_cnt [2];
  bit m_tc  [2];
  int m_pre [2] = '{4, 1};
  int m_mod [2] = '{26, 256};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_ps[i] = 0; m_cnt[i] = 0; m_tc[i] = 1'b0;
    end
  endtask

  task automatic model_advance(input int i);
    bit t;
    t = (m_ps[i] == m_pre[i] - 1);
    if (rst) begin
      m_ps[i] = 0; m_cnt[i] = 0; m_tc[i] = 1'b0;
      return;
    end
    m_ps[i] = t ? 0 : m_ps[i] + 1;
    m_tc[i] = 1'b0;
    if (clear) begin
      m_cnt[i] = 0;
    end else if (load && (`ifdef CONTADOR_LOAD_EN 1 `else 0 `endif)) begin
      m_cnt[i] = (int'(load_value) > m_mod[i] - 1) ? m_mod[i] - 1 : int'(load_value);
    end else if (t && !hold) begin
      if (up_down) begin
        if (m_cnt[i] == m_mod[i] - 1) begin m_cnt[i] = 0; m_tc[i] = 1'b1; end
        else m_cnt[i] = m_cnt[i] + 1;
      end else begin
        if (m_cnt[i] == 0) begin m_cnt[i] = m_mod[i] - 1; m_tc[i] = 1'b1; end
        else m_cnt[i] = m_cnt[i] - 1;
      end
    end
  endtask

  // Called at a falling edge with inputs already applied.
  task automatic step();
    exp_t e;
    check("tick_a_pre", 32'(tick_a), 32'(m_ps[0] == m_pre[0] - 1));
    check("tick_b_pre", 32'(tick_b), 32'(m_ps[1] == m_pre[1] - 1));
    for (int i = 0; i < 2; i++) begin
      model_advance(i);
      e.cnt  = 8'(m_cnt[i]);
      e.tc   = m_tc[i];
      e.tick = (m_ps[i] == m_pre[i] - 1);
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("count_a", 32'(count_a), 32'(e.cnt));
    check("tc_a",    32'(tc_a),    32'(e.tc));
    check("tick_a",  32'(tick_a),  32'(e.tick));
    e = sb.pop_front();
    check("count_b", 32'(count_b), 32'(e.cnt));
    check("tc_b",    32'(tc_b),    32'(e.tc));
    check("tick_b",  32'(tick_b),  32'(e.tick));
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    model_reset();
    @(negedge clk);

    // reset state
    rst = 1'b1;
    run(3);
    check("reset_count_a", 32'(count_a), 0);
    check("reset_tc_a", 32'(tc_a), 0);
    check("reset_tick_a", 32'(tick_a), 0);
    check("reset_tick_b", 32'(tick_b), 1);

    // up-count and wraps
    rst = 1'b0; up_down = 1'b1;
    run(4);
    check("up_first_tick_a", 32'(count_a), 1);
    check("up_every_clk_b", 32'(count_b), 4);
    run(96);
    check("up_top_a", 32'(count_a), 25);
    run(4);
    check("up_wrap_a", 32'(count_a), 0);
    check("up_wrap_tc_a", 32'(tc_a), 1);
    run(1);
    check("up_tc_one_clk_a", 32'(tc_a), 0);
    run(151);
    check("wrap_255_b", 32'(count_b), 0);
    check("wrap_255_tc_b", 32'(tc_b), 1);

    // down-count from reset
    rst = 1'b1; run(1);
    rst = 1'b0; up_down = 1'b0;
    run(4);
    check("down_first_a", 32'(count_a), 25);
    check("down_first_tc_a", 32'(tc_a), 1);
    check("down_b", 32'(count_b), 252);
    run(4);
    check("down_next_a", 32'(count_a), 24);
    check("down_next_tc_a", 32'(tc_a), 0);
    run(8);

    // hold across three ticks
    rst = 1'b1; run(1);
    rst = 1'b0; up_down = 1'b1;
    run(40);
    check("pre_hold_a", 32'(count_a), 10);
    hold = 1'b1;
    run(12);
    check("held_a", 32'(count_a), 10);
    hold = 1'b0;
    run(4);
    check("post_hold_a", 32'(count_a), 11);

    // clear on a tick edge
    rst = 1'b1; run(1);
    rst = 1'b0;
    run(28);
    check("pre_clear_a", 32'(count_a), 7);
    run(3);
    clear = 1'b1;
    run(1);
    check("clear_a", 32'(count_a), 0);
    check("clear_tc_a", 32'(tc_a), 0);
    clear = 1'b0;

    // reset mid-sequence: next tick four clk after release
    run(6);
    rst = 1'b1; run(1);
    rst = 1'b0;
    run(3);
    check("rst_mid_no_tick_a", 32'(count_a), 0);
    run(1);
    check("rst_mid_first_tick_a", 32'(count_a), 1);

`ifdef CONTADOR_LOAD_EN
    load_value = 8'd200; load = 1'b1;
    run(1);
    load = 1'b0;
    check("load_clamp_a", 32'(count_a), 25);
    check("load_b", 32'(count_b), 200);
    rst = 1'b1; run(1);
    rst = 1'b0;
    run(3);
    load_value = 8'd12; load = 1'b1;
    run(1);
    load = 1'b0;
    check("load_over_tick_a", 32'(count_a), 12);
    run(4);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_contador_mod_tick
